// File: rtl/key44_pkg.sv
// key44_pkg: shared types and constants for the key44 keypad scanner.
//   state_e    - scanner FSM states (IDLE, SCAN0..SCAN3)
//   COL_*      - active-low column drive patterns
//   ROW_IDLE   - row pattern with no key pressed
//   low_row()  - lowest-indexed active (low) row bit
//   col_drive()- column drive pattern for a state
//   scan_col() - column index scanned in a state
package key44_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN0,
        SCAN1,
        SCAN2,
        SCAN3
    } state_e;

    localparam logic [3:0] COL_ALL  = 4'b0000;
    localparam logic [3:0] COL0     = 4'b1110;
    localparam logic [3:0] COL1     = 4'b1101;
    localparam logic [3:0] COL2     = 4'b1011;
    localparam logic [3:0] COL3     = 4'b0111;
    localparam logic [3:0] ROW_IDLE = 4'b1111;

    // Lowest-indexed row pulled low wins; only meaningful when row != ROW_IDLE.
    function automatic logic [1:0] low_row(input logic [3:0] row);
        logic [1:0] idx;
        if (!row[0])      idx = 2'd0;
        else if (!row[1]) idx = 2'd1;
        else if (!row[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

    function automatic logic [3:0] col_drive(input state_e s);
        logic [3:0] c;
        case (s)
            SCAN0:   c = COL0;
            SCAN1:   c = COL1;
            SCAN2:   c = COL2;
            SCAN3:   c = COL3;
            default: c = COL_ALL;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] scan_col(input state_e s);
        logic [1:0] j;
        case (s)
            SCAN1:   j = 2'd1;
            SCAN2:   j = 2'd2;
            SCAN3:   j = 2'd3;
            default: j = 2'd0;
        endcase
        return j;
    endfunction

endpackage

// File: rtl/key44_step_timer.sv
// key44_step_timer: divides the clock into scan steps of SCAN_DIV cycles.
//   clk      in  - system clock
//   reset    in  - asynchronous active-high reset (count returns to 0)
//   step_end out - high on the last cycle of every step
module key44_step_timer #(
    parameter int unsigned SCAN_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic step_end
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        step_end = (cnt_q == LAST);
        cnt_d    = step_end ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/key44.sv
// key44: 4x4 active-low matrix keypad scanner with two-pass debounce.
//   clk       in  - system clock
//   reset     in  - asynchronous active-high reset
//   row       in  [3:0] - keypad rows, active-low
//   col       out [3:0] - keypad column drive, active-low, registered
//   key_value out [3:0] - last confirmed key code {row, col}, registered
// IDLE drives all columns until any key pulls a row low, then one pass
// walks SCAN0..SCAN3. A code is confirmed when two consecutive passes
// report the same first hit.
module key44
    import key44_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_value
);

    state_e     state_q, state_d;
    logic [3:0] col_q, col_d;
    logic [3:0] key_value_q, key_value_d;
    logic       cand_valid_q, cand_valid_d;
    logic [3:0] cand_code_q, cand_code_d;
    logic       prev_valid_q, prev_valid_d;
    logic [3:0] prev_code_q, prev_code_d;

    logic       step_end;
    logic       hit;
    logic [3:0] hit_code;
    logic       pass_hit;
    logic [3:0] pass_code;

    key44_step_timer #(
        .SCAN_DIV(SCAN_DIV)
    ) u_step_timer (
        .clk      (clk),
        .reset    (reset),
        .step_end (step_end)
    );

    assign col       = col_q;
    assign key_value = key_value_q;

    // State register; col is registered from the next state so it changes
    // exactly at step boundaries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= COL_ALL;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (step_end) begin
            case (state_q)
                IDLE:    if (row != ROW_IDLE) state_d = SCAN0;
                SCAN0:   state_d = SCAN1;
                SCAN1:   state_d = SCAN2;
                SCAN2:   state_d = SCAN3;
                SCAN3:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic.
    always_comb begin
        col_d = col_drive(state_d);
    end

    // Hit detection and pass bookkeeping.
    always_comb begin
        hit      = step_end && (row != ROW_IDLE);
        hit_code = {low_row(row), scan_col(state_q)};

        // The SCAN3 sample itself may be the first hit of the pass.
        pass_hit  = cand_valid_q || hit;
        pass_code = cand_valid_q ? cand_code_q : hit_code;

        cand_valid_d = cand_valid_q;
        cand_code_d  = cand_code_q;
        prev_valid_d = prev_valid_q;
        prev_code_d  = prev_code_q;
        key_value_d  = key_value_q;

        if (step_end) begin
            case (state_q)
                IDLE: begin
                    cand_valid_d = 1'b0;
                    // An idle step with nothing pressed breaks the pass chain.
                    if (row == ROW_IDLE) prev_valid_d = 1'b0;
                end
                SCAN3: begin
                    if (pass_hit && prev_valid_q && (prev_code_q == pass_code))
                        key_value_d = pass_code;
                    prev_valid_d = pass_hit;
                    prev_code_d  = pass_code;
                    cand_valid_d = 1'b0;
                end
                default: begin
                    if (hit && !cand_valid_q) begin
                        cand_valid_d = 1'b1;
                        cand_code_d  = hit_code;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_value_q  <= 4'h0;
            cand_valid_q <= 1'b0;
            cand_code_q  <= 4'h0;
            prev_valid_q <= 1'b0;
            prev_code_q  <= 4'h0;
        end else begin
            key_value_q  <= key_value_d;
            cand_valid_q <= cand_valid_d;
            cand_code_q  <= cand_code_d;
            prev_valid_q <= prev_valid_d;
            prev_code_q  <= prev_code_d;
        end
    end

endmodule

// File: tb/tb_key44.sv
// tb_key44: scoreboard bench for key44 with SCAN_DIV=1 and SCAN_DIV=4 instances.
// A virtual keypad turns the driven columns into row levels. The stimulus
// side works one pass at a time and pushes the expected key_value for each
// pass; per-instance monitors pop and compare whenever a pass completes
// (column drive returns from 0111 to 0000) and also check column order and
// step hold times.
module tb_key44;

    localparam int SD0 = 1;
    localparam int SD1 = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_w [2];
    logic [3:0] col_w [2];
    logic [3:0] kv_w  [2];

    logic       ka_on [2];
    logic       kb_on [2];
    logic [3:0] ka    [2];
    logic [3:0] kb    [2];

    logic       prev_v [2];
    logic [3:0] prev_c [2];
    logic [3:0] kv_m   [2];
    logic [3:0] exp_q0 [$];
    logic [3:0] exp_q1 [$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    key44 #(.SCAN_DIV(SD0)) dut1 (
        .clk(clk), .reset(reset), .row(row_w[0]), .col(col_w[0]), .key_value(kv_w[0])
    );
    key44 #(.SCAN_DIV(SD1)) dut4 (
        .clk(clk), .reset(reset), .row(row_w[1]), .col(col_w[1]), .key_value(kv_w[1])
    );

    // Virtual keypad: a pressed key {r,c} pulls row r low while column c is driven low.
    function automatic logic [3:0] row_of(input logic [3:0] c, input logic a_on, input logic [3:0] a,
                                          input logic b_on, input logic [3:0] b);
        logic [3:0] r;
        r = 4'b1111;
        if (a_on && !c[a[1:0]]) r[a[3:2]] = 1'b0;
        if (b_on && !c[b[1:0]]) r[b[3:2]] = 1'b0;
        return r;
    endfunction

    assign row_w[0] = row_of(col_w[0], ka_on[0], ka[0], kb_on[0], kb[0]);
    assign row_w[1] = row_of(col_w[1], ka_on[1], ka[1], kb_on[1], kb[1]);

    function automatic int sd_of(input int idx);
        return (idx == 0) ? SD0 : SD1;
    endfunction

    // Position of a key in scan order: column first, then row.
    function automatic int ord(input logic [3:0] k);
        return int'(k[1:0]) * 4 + int'(k[3:2]);
    endfunction

    function automatic logic [3:0] next_col(input logic [3:0] c);
        case (c)
            4'b0000: return 4'b1110;
            4'b1110: return 4'b1101;
            4'b1101: return 4'b1011;
            4'b1011: return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at the start of an IDLE step: set the keys held for this pass
    // and record the expected key_value once the pass completes.
    task automatic start_pass(input int idx, input logic a_on, input logic [3:0] a,
                              input logic b_on, input logic [3:0] b);
        logic [3:0] code;
        ka_on[idx] = a_on; ka[idx] = a;
        kb_on[idx] = b_on; kb[idx] = b;
        if (!a_on && !b_on) begin
            prev_v[idx] = 1'b0;
        end else begin
            if (a_on && b_on) code = (ord(a) <= ord(b)) ? a : b;
            else              code = a_on ? a : b;
            if (prev_v[idx] && prev_c[idx] == code) kv_m[idx] = code;
            prev_v[idx] = 1'b1;
            prev_c[idx] = code;
            if (idx == 0) exp_q0.push_back(kv_m[idx]);
            else          exp_q1.push_back(kv_m[idx]);
        end
    endtask

    task automatic pass(input int idx, input logic a_on, input logic [3:0] a,
                        input logic b_on, input logic [3:0] b);
        start_pass(idx, a_on, a, b_on, b);
        repeat ((a_on || b_on) ? 5 * sd_of(idx) : sd_of(idx)) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        chk("rst_col1", col_w[0], 4'b0000);
        chk("rst_kv1",  kv_w[0],  4'h0);
        chk("rst_col4", col_w[1], 4'b0000);
        chk("rst_kv4",  kv_w[1],  4'h0);
        for (int d = 0; d < 2; d++) begin
            ka_on[d] = 1'b0; kb_on[d] = 1'b0; ka[d] = 4'h0; kb[d] = 4'h0;
            prev_v[d] = 1'b0; prev_c[d] = 4'h0; kv_m[d] = 4'h0;
        end
        exp_q0.delete();
        exp_q1.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic monitor(input int idx);
        logic [3:0] last;
        int         run;
        last = 4'b0000;
        run  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                last = 4'b0000;
                run  = 0;
            end else if (col_w[idx] === last) begin
                run++;
            end else begin
                chk("col_next", col_w[idx], next_col(last));
                if (last == 4'b0000) chk("idle_hold", run % sd_of(idx), 0);
                else                 chk("col_hold", run, sd_of(idx));
                if (last == 4'b0111 && col_w[idx] == 4'b0000) begin
                    if ((idx == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        total++;
                        bad++;
                        $display("FAIL pass_pop: got unexpected pass (inst %0d) expected none", idx);
                    end else if (idx == 0) begin
                        chk("key_value1", kv_w[0], exp_q0.pop_front());
                    end else begin
                        chk("key_value4", kv_w[1], exp_q1.pop_front());
                    end
                end
                last = col_w[idx];
                run  = 1;
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        int         r;
        logic       a_on, b_on;
        logic [3:0] a, b;

        apply_reset();

        // Key row0/col3 confirmed on the second pass.
        pass(0, 1'b1, 4'h3, 1'b0, 4'h0);
        pass(0, 1'b1, 4'h3, 1'b0, 4'h0);
        chk("kv_after_two", kv_w[0], 4'h3);

        // Reset in the middle of SCAN2.
        ka_on[0] = 1'b1; ka[0] = 4'h3;
        n = 0;
        while (col_w[0] !== 4'b1011 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_scan2", col_w[0], 4'b1011);
        #2;
        apply_reset();
        @(posedge clk);
        #1 chk("idle_resume", col_w[0], 4'b0000);

        // No key for 1000 cycles.
        for (int i = 0; i < 1000; i++) pass(0, 1'b0, 4'h0, 1'b0, 4'h0);
        chk("idle_col", col_w[0], 4'b0000);
        chk("idle_kv",  kv_w[0],  4'h0);

        // Held key: continuous passes, value stays.
        for (int i = 0; i < 3000; i++) pass(0, 1'b1, 4'h3, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) pass(0, 1'b0, 4'h0, 1'b0, 4'h0);
        chk("release_keeps", kv_w[0], 4'h3);

        for (int i = 0; i < 3; i++) pass(0, 1'b1, 4'h9, 1'b0, 4'h0);
        chk("kv_9", kv_w[0], 4'h9);
        for (int i = 0; i < 2; i++) pass(0, 1'b1, 4'hF, 1'b0, 4'h0);
        chk("kv_F", kv_w[0], 4'hF);

        // Single-pass press, then release.
        pass(0, 1'b1, 4'h5, 1'b0, 4'h0);
        pass(0, 1'b0, 4'h0, 1'b0, 4'h0);
        pass(0, 1'b0, 4'h0, 1'b0, 4'h0);
        chk("one_pass", kv_w[0], 4'hF);

        // Alternating codes never confirm.
        for (int i = 0; i < 8; i++) pass(0, 1'b1, (i % 2 == 0) ? 4'h5 : 4'h6, 1'b0, 4'h0);
        chk("alternate", kv_w[0], 4'hF);
        pass(0, 1'b0, 4'h0, 1'b0, 4'h0);

        // Multi-key: earliest in scan order wins.
        for (int i = 0; i < 2; i++) pass(0, 1'b1, 4'h7, 1'b1, 4'hE);
        chk("multi_col", kv_w[0], 4'hE);
        for (int i = 0; i < 2; i++) pass(0, 1'b1, 4'hA, 1'b1, 4'h2);
        chk("multi_row", kv_w[0], 4'h2);
        pass(0, 1'b0, 4'h0, 1'b0, 4'h0);

        // Random passes.
        a_on = 1'b0; b_on = 1'b0; a = 4'h0; b = 4'h0;
        for (int i = 0; i < 100; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                a_on = 1'b0; b_on = 1'b0;
            end else if (r < 6) begin
                // keep the previous keys to allow confirmations
            end else begin
                a_on = 1'b1;
                a    = 4'($urandom_range(0, 15));
                b_on = (r == 9);
                b    = 4'($urandom_range(0, 15));
            end
            pass(0, a_on, a, b_on, b);
        end
        pass(0, 1'b0, 4'h0, 1'b0, 4'h0);
        chk("rand_final", kv_w[0], kv_m[0]);

        // SCAN_DIV=4: key row1/col0, 40-cycle confirmation latency.
        apply_reset();
        start_pass(1, 1'b1, 4'h4, 1'b0, 4'h0);
        repeat (20) @(posedge clk);
        #1;
        start_pass(1, 1'b1, 4'h4, 1'b0, 4'h0);
        repeat (19) @(posedge clk);
        #1 chk("lat_before", kv_w[1], 4'h0);
        @(posedge clk);
        #1 chk("lat_at_40", kv_w[1], 4'h4);
        pass(1, 1'b1, 4'h4, 1'b0, 4'h0);
        pass(1, 1'b0, 4'h0, 1'b0, 4'h0);
        chk("div4_hold", kv_w[1], 4'h4);

        @(negedge clk);
        #1;
        chk("q1_drained", exp_q0.size(), 0);
        chk("q4_drained", exp_q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
